// File: rtl/nn_pkg.sv
// Shared definitions for the image-buffer read sequencer: FSM encoding and word geometry.
package nn_pkg;

  localparam int PIX_PER_WORD = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/nn_img_rd_fifo.sv
// Two-entry synchronous FIFO that absorbs buffer read data while the stream is stalled.
module nn_img_rd_fifo #(
  parameter int WIDTH = 49
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: only two entries, so storage is reset and the stream data reads 0 after reset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_full  = (count_q == 2'd2);
  assign o_empty = (count_q == 2'd0);
  assign o_count = count_q;

endmodule

// File: rtl/nn_img_rd.sv
// Window read sequencer: walks rows x cols of the image buffer and streams the words out.
module nn_img_rd
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 12,
  parameter int TOTAL_DATA_WIDTH = DATA_WIDTH * PIX_PER_WORD,
  parameter int CNT_WIDTH        = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [ADDR_WIDTH-1:0]       i_base_addr,
  input  logic [ADDR_WIDTH-1:0]       i_row_stride,
  input  logic [CNT_WIDTH-1:0]        i_row_num,
  input  logic [CNT_WIDTH-1:0]        i_col_num,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_rd_en,
  output logic [ADDR_WIDTH-1:0]       o_rd_addr,
  input  logic [TOTAL_DATA_WIDTH-1:0] i_rd_data,
  output logic [TOTAL_DATA_WIDTH-1:0] o_data,
  output logic                        o_valid,
  output logic                        o_last,
  input  logic                        i_ready
);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_WIDTH-1:0]  row_num_q, row_num_d;
  logic [CNT_WIDTH-1:0]  col_num_q, col_num_d;
  logic [CNT_WIDTH-1:0]  row_q, row_d;
  logic [CNT_WIDTH-1:0]  col_q, col_d;
  logic                  arm_q, arm_d;
  logic                  done_q, done_d;
  logic                  rdv_q, rdv_last_q;

  logic                        fifo_full, fifo_empty;
  logic [1:0]                  fifo_count;
  logic [TOTAL_DATA_WIDTH:0]   fifo_head;
  logic                        pop;
  logic                        rd_en;
  logic                        last_addr;
  logic                        last_col;
  logic [2:0]                  pending;

  assign pop       = o_valid && i_ready;
  assign last_col  = (col_q == col_num_q - CNT_WIDTH'(1));
  assign last_addr = last_col && (row_q == row_num_q - CNT_WIDTH'(1));

  // Words that will occupy the FIFO after this edge; a new read must still fit if the stream stalls.
  assign pending = {1'b0, fifo_count} + {2'b00, rdv_q} - {2'b00, pop};
  assign rd_en   = (state_q == ST_RUN) && !arm_q && (pending < 3'd2);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    stride_d   = stride_q;
    row_base_d = row_base_q;
    rd_addr_d  = rd_addr_q;
    row_num_d  = row_num_q;
    col_num_d  = col_num_q;
    row_d      = row_q;
    col_d      = col_q;
    arm_d      = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_row_num == '0 || i_col_num == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = ST_RUN;
            arm_d      = 1'b1;
            stride_d   = i_row_stride;
            row_base_d = i_base_addr;
            rd_addr_d  = i_base_addr;
            row_num_d  = i_row_num;
            col_num_d  = i_col_num;
            row_d      = '0;
            col_d      = '0;
          end
        end
      end
      ST_RUN: begin
        if (rd_en) begin
          if (last_addr) begin
            state_d = ST_DRAIN;
          end else if (last_col) begin
            col_d      = '0;
            row_d      = row_q + CNT_WIDTH'(1);
            row_base_d = row_base_q + stride_q;
            rd_addr_d  = row_base_q + stride_q;
          end else begin
            col_d     = col_q + CNT_WIDTH'(1);
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Leave once the last word has been accepted and nothing remains in flight.
        if (!rdv_q && (fifo_empty || (!fifo_full && pop))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      stride_q   <= '0;
      row_base_q <= '0;
      rd_addr_q  <= '0;
      row_num_q  <= '0;
      col_num_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
      arm_q      <= 1'b0;
      done_q     <= 1'b0;
      rdv_q      <= 1'b0;
      rdv_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stride_q   <= stride_d;
      row_base_q <= row_base_d;
      rd_addr_q  <= rd_addr_d;
      row_num_q  <= row_num_d;
      col_num_q  <= col_num_d;
      row_q      <= row_d;
      col_q      <= col_d;
      arm_q      <= arm_d;
      done_q     <= done_d;
      rdv_q      <= rd_en;
      rdv_last_q <= rd_en && last_addr;
    end
  end

  nn_img_rd_fifo #(
    .WIDTH(TOTAL_DATA_WIDTH + 1)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (rdv_q),
    .i_data  ({rdv_last_q, i_rd_data}),
    .i_pop   (pop),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign o_valid   = !fifo_empty;
  assign o_data    = fifo_head[TOTAL_DATA_WIDTH-1:0];
  assign o_last    = o_valid && fifo_head[TOTAL_DATA_WIDTH];
  assign o_rd_en   = rd_en;
  assign o_rd_addr = rd_addr_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = done_q;

endmodule

// File: tb/tb_nn_img_rd.sv
// Directed bench for nn_img_rd with a registered buffer model and an address/beat scoreboard.
module tb_nn_img_rd;

  localparam int DW = 8;
  localparam int AW = 12;
  localparam int TW = 48;
  localparam int CW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [AW-1:0] i_row_stride = '0;
  logic [CW-1:0] i_row_num = '0;
  logic [CW-1:0] i_col_num = '0;
  logic          o_busy, o_done, o_rd_en, o_valid, o_last;
  logic [AW-1:0] o_rd_addr;
  logic [TW-1:0] i_rd_data = '0;
  logic [TW-1:0] o_data;
  logic          i_ready = 1'b0;

  typedef struct packed {
    logic          last;
    logic [TW-1:0] data;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            n_checks = 0;
  int            n_pass = 0;

  always #5 i_clk = ~i_clk;

  nn_img_rd #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOTAL_DATA_WIDTH(TW), .CNT_WIDTH(CW)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_row_stride(i_row_stride),
    .i_row_num(i_row_num), .i_col_num(i_col_num),
    .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .i_rd_data(i_rd_data), .o_data(o_data), .o_valid(o_valid), .o_last(o_last),
    .i_ready(i_ready)
  );

  function automatic logic [TW-1:0] word_at(input logic [AW-1:0] a);
    return {a, ~a, a ^ 12'hA5C, a + 12'h003};
  endfunction

  // Image buffer: one-cycle registered read.
  always @(posedge i_clk) begin
    if (o_rd_en) i_rd_data <= word_at(o_rd_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {59'd0, o_busy, o_done, o_rd_en, o_valid, o_last}, 64'd0);
    check({tag, "_bus"}, {4'd0, o_rd_addr, o_data}, 64'd0);
  endtask

  task automatic run_window(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                            input logic [CW-1:0] rows, input logic [CW-1:0] cols,
                            input int ready_mode, input int restart_cyc, input int abort_after);
    int    n;
    int    issued;
    int    consumed;
    int    first_rd;
    int    first_v;
    int    last_hs;
    int    done_cyc;
    logic  stalled;
    logic  hs;
    beat_t held;
    beat_t b;
    logic [AW-1:0] a;
    n        = int'(rows) * int'(cols);
    issued   = 0;
    consumed = 0;
    first_rd = -1;
    first_v  = -1;
    last_hs  = -1;
    done_cyc = -1;
    stalled  = 1'b0;
    held     = '0;
    for (int r = 0; r < int'(rows); r++) begin
      for (int c = 0; c < int'(cols); c++) begin
        a = base + AW'(r) * stride + AW'(c);
        addr_q.push_back(a);
        b.last = (r == int'(rows) - 1) && (c == int'(cols) - 1);
        b.data = word_at(a);
        exp_q.push_back(b);
      end
    end

    @(negedge i_clk);
    i_base_addr  = base;
    i_row_stride = stride;
    i_row_num    = rows;
    i_col_num    = cols;
    i_start      = 1'b1;

    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge i_clk);
      i_start = (cyc == restart_cyc);
      i_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      #1;
      hs = o_valid && i_ready;
      if (cyc == 0) check("busy_after_start", o_busy, n != 0);
      if (stalled) check("stall_hold", {o_valid, o_last, o_data}, {1'b1, held});
      stalled = 1'b0;
      if (o_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        issued++;
        if (addr_q.size() == 0) check("extra_read", 1, 0);
        else check("rd_addr", o_rd_addr, addr_q.pop_front());
        check("outstanding_le_2", (issued - (consumed + int'(hs))) <= 2, 1);
      end
      if (o_valid && first_v < 0) first_v = cyc;
      if (hs) begin
        consumed++;
        last_hs = cyc;
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else check("beat", {o_last, o_data}, exp_q.pop_front());
      end else if (o_valid) begin
        stalled = 1'b1;
        held    = {o_last, o_data};
      end
      if (abort_after > 0 && hs && consumed == abort_after) begin
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        addr_q.delete();
        exp_q.delete();
        return;
      end
      if (o_done) begin
        done_cyc = cyc;
        check("busy_low_at_done", o_busy, 0);
        break;
      end
    end

    if (done_cyc < 0) begin
      check("done_timeout", 0, 1);
      i_rst_n = 1'b0;
      #1;
      i_rst_n = 1'b1;
    end
    check("beat_count", consumed, n);
    check("queues_drained", addr_q.size() + exp_q.size(), 0);
    addr_q.delete();
    exp_q.delete();
    if (n == 0) begin
      check("zero_done_cycle", done_cyc, 0);
      check("zero_no_activity", issued + (first_v >= 0 ? 1 : 0), 0);
    end else begin
      check("done_after_last", done_cyc, last_hs + 1);
      if (ready_mode == 0) begin
        check("first_rd_cycle", first_rd, 1);
        check("first_valid_cycle", first_v, 3);
        check("last_beat_cycle", last_hs, n + 2);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      #1;
      check("idle_tail", {o_rd_en, o_valid, o_done, o_busy}, 4'b0000);
    end
  endtask

  initial begin
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;

    run_window(12'h010, 12'h020, 8'd2, 8'd3, 0, -1, 0);
    run_window(12'h010, 12'h020, 8'd2, 8'd3, 1, -1, 0);
    run_window(12'hFFE, 12'h004, 8'd2, 8'd3, 0, -1, 0);
    run_window(12'h040, 12'h001, 8'd0, 8'd5, 0, -1, 0);
    run_window(12'h200, 12'h040, 8'd2, 8'd3, 0, 4, 0);
    run_window(12'h010, 12'h020, 8'd2, 8'd3, 0, -1, 3);
    run_window(12'h100, 12'h010, 8'd3, 8'd2, 0, -1, 0);
    run_window(12'h300, 12'h008, 8'd3, 8'd4, 1, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
